// File: rtl/bch_err_apply_pkg.sv
// Shared sizing helpers for the BCH error-application stage.
// P layout: P[15:0] = data length K, P[31:16] = correction capability t.
package bch_err_apply_pkg;

  localparam int unsigned BCH_PARAM_SZ = 32;
  localparam logic [BCH_PARAM_SZ-1:0] BCH_SANE = {16'd2, 16'd61};

  function automatic int unsigned bch_data_bits(input logic [BCH_PARAM_SZ-1:0] p);
    return int'(p & 32'h0000_FFFF);
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Bits needed to index n entries; never less than one so ports stay legal.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bch_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module bch_sdp_ram #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bch_err_apply.sv
// Buffers raw codeword words and XORs them with the decoder's error masks.
// Optional BCH_ERR_APPLY_COUNT_EN adds a saturating corrected-bit counter.
module bch_err_apply
  import bch_err_apply_pkg::*;
#(
  parameter logic [BCH_PARAM_SZ-1:0] P      = BCH_SANE,
  parameter int unsigned             BITS   = 1,
  parameter int unsigned             BLOCKS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] err,
  input  logic            err_valid,
  input  logic            err_first,
  input  logic            err_last,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  output logic            underflow
`ifdef BCH_ERR_APPLY_COUNT_EN
  ,
  output logic [31:0]     corrected
`endif
);

  localparam int unsigned K     = bch_data_bits(P);
  localparam int unsigned WORDS = ceil_div(K, BITS);
  localparam int unsigned CAP   = BLOCKS * WORDS;
  localparam int unsigned AW    = log2(CAP);
  localparam int unsigned CW    = log2(CAP + 1);
  localparam int unsigned WW    = log2(WORDS);
  localparam int unsigned PAD   = K % BITS;

  // Handshake: a word transfers on in_valid && in_ready; err_valid is a pure
  // push (no ready) and the output side has no backpressure.
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wcnt_q, wcnt_d, word_idx;
  logic            wr_en, rd_en, is_last;
  logic [BITS-1:0] last_mask, mask_d, mask_q, err_q, ram_rdata;
  logic            out_valid_q, out_first_q, out_last_q, underflow_q;
  logic            unused_err_last;

  assign unused_err_last = err_last;

  assign in_ready = (count_q < CW'(CAP));
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = err_valid && (count_q != '0);

  // err_first always lands on word 0, which also resyncs a misaligned block.
  assign word_idx = err_first ? '0 : wcnt_q;
  assign is_last  = (word_idx == WW'(WORDS - 1));

  always_comb begin
    for (int unsigned b = 0; b < BITS; b++) begin
      last_mask[b] = (PAD == 0) || (b < PAD);
    end
  end

  assign mask_d = is_last ? last_mask : '1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wcnt_d   = wcnt_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == AW'(CAP - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == AW'(CAP - 1)) ? '0 : rd_ptr_q + AW'(1);
      wcnt_d   = is_last ? '0 : word_idx + WW'(1);
    end
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (rd_en && !wr_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wcnt_q      <= '0;
      err_q       <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= rd_en;
      out_first_q <= rd_en && (word_idx == '0);
      out_last_q  <= rd_en && is_last;
      if (rd_en) begin
        err_q  <= err & mask_d;
        mask_q <= mask_d;
      end
      if (err_valid && (count_q == '0)) underflow_q <= 1'b1;
    end
  end

  bch_sdp_ram #(
    .DEPTH (CAP),
    .WIDTH (BITS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register carries no reset, so gate the word with its valid.
  assign out_data  = out_valid_q ? ((ram_rdata & mask_q) ^ err_q) : '0;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign underflow = underflow_q;

`ifdef BCH_ERR_APPLY_COUNT_EN
  logic [31:0] corrected_q;
  logic [32:0] corr_sum;

  assign corr_sum = {1'b0, corrected_q} + 33'($countones(err & mask_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corrected_q <= '0;
    end else if (rd_en) begin
      corrected_q <= corr_sum[32] ? '1 : corr_sum[31:0];
    end
  end

  assign corrected = corrected_q;
`endif

endmodule

// File: tb/tb_bch_err_apply.sv
// Randomised bench for bch_err_apply (BITS=8, K=61, BLOCKS=2) against a queue model.
module tb_bch_err_apply;

  localparam int unsigned W      = 8;
  localparam int unsigned K      = 61;
  localparam int unsigned BLOCKS = 2;
  localparam int unsigned WORDS  = (K + W - 1) / W;
  localparam int unsigned CAP    = BLOCKS * WORDS;
  localparam int unsigned PADB   = K % W;
  localparam logic [W-1:0] LAST_MASK = (PADB == 0) ? {W{1'b1}} : W'((1 << PADB) - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] err = '0;
  logic         err_valid = 1'b0;
  logic         err_first = 1'b0;
  logic         err_last = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic         underflow;
`ifdef BCH_ERR_APPLY_COUNT_EN
  logic [31:0]  corrected;
`endif

  bch_err_apply #(
    .P      ({16'd2, 16'd61}),
    .BITS   (W),
    .BLOCKS (BLOCKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .err       (err),
    .err_valid (err_valid),
    .err_first (err_first),
    .err_last  (err_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .underflow (underflow)
`ifdef BCH_ERR_APPLY_COUNT_EN
    ,
    .corrected (corrected)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] buf_q[$];
  logic [W-1:0] exp_q[$];
  int           pos = 0;
  logic         exp_uf = 1'b0;
  longint       exp_corr = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    err_valid = 1'b0;
    err_first = 1'b0;
    reset     = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef BCH_ERR_APPLY_COUNT_EN
    check("rst_corrected", corrected, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    buf_q.delete();
    exp_q.delete();
    pos      = 0;
    exp_uf   = 1'b0;
    exp_corr = 0;
  endtask

  // One clock: drive inputs, predict, then compare just after the edge.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ev,
                       input logic [W-1:0] ed, input logic ef);
    logic         do_wr, exp_v, exp_f, exp_l;
    logic [W-1:0] m, d;
    in_valid  = iv;
    in_data   = id;
    err_valid = ev;
    err       = ed;
    err_first = ef;
    err_last  = 1'b0;
    check("in_ready", 32'(in_ready), 32'(buf_q.size() < CAP));
    do_wr = iv && (buf_q.size() < CAP);
    exp_v = 1'b0;
    exp_f = 1'b0;
    exp_l = 1'b0;
    if (ev && buf_q.size() == 0) exp_uf = 1'b1;
    if (ev && buf_q.size() > 0) begin
      if (ef) pos = 0;
      exp_f = (pos == 0);
      exp_l = (pos == WORDS - 1);
      m = exp_l ? LAST_MASK : {W{1'b1}};
      d = buf_q.pop_front();
      exp_q.push_back((d ^ ed) & m);
      exp_corr = exp_corr + $countones(ed & m);
      if (exp_corr > 64'hFFFF_FFFF) exp_corr = 64'hFFFF_FFFF;
      pos = exp_l ? 0 : pos + 1;
      exp_v = 1'b1;
    end
    if (do_wr) buf_q.push_back(id);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_v));
    check("underflow", 32'(underflow), 32'(exp_uf));
    if (exp_v) begin
      check("out_data",  32'(out_data),  32'(exp_q.pop_front()));
      check("out_first", 32'(out_first), 32'(exp_f));
      check("out_last",  32'(out_last),  32'(exp_l));
`ifdef BCH_ERR_APPLY_COUNT_EN
      check("corrected", corrected, 32'(exp_corr));
`endif
    end
  endtask

  function automatic logic [W-1:0] rand_err();
    return ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
  endfunction

  task automatic drain();
    while (buf_q.size() > 0) cycle(1'b0, '0, 1'b1, rand_err(), pos == 0);
  endtask

  initial begin
    do_reset();

    // Mask with empty buffer right after reset: sticky underflow, no output.
    cycle(1'b0, '0, 1'b1, 8'h55, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    do_reset();

    // All-ones block with 8'h81 applied to word 3.
    for (int i = 0; i < WORDS; i++) cycle(1'b1, 8'hFF, 1'b0, '0, 1'b0);
    for (int i = 0; i < WORDS; i++) cycle(1'b0, '0, 1'b1, (i == 3) ? 8'h81 : 8'h00, i == 0);

    // Fill both blocks without reading; in_ready must drop, one read reopens it.
    for (int i = 0; i < CAP + 2; i++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, rand_err(), 1'b1);
    cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    drain();

    // Steady simultaneous write/read across the pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    for (int i = 0; i < 3 * WORDS + 5; i++)
      cycle(1'b1, W'($urandom), 1'b1, rand_err(), pos == 0);
    drain();

    // Reset in the middle of a block, then a fresh block.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, rand_err(), i == 0);
    do_reset();
    for (int i = 0; i < WORDS; i++) cycle(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    for (int i = 0; i < WORDS; i++) cycle(1'b0, '0, 1'b1, rand_err(), i == 0);

    // Random traffic, including occasional misframed err_first.
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 2) != 0,
            rand_err(), (pos == 0) || ($urandom_range(0, 19) == 0));
    drain();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_err_apply.md
# bch_err_apply

Error-application stage that sits directly downstream of the BCH error decoder's Chien search. Buffers raw codeword data words as they arrive from the channel, then XORs each buffered word with the decoder's per-cycle `err` vector when that vector is presented, emitting corrected data with block framing. Decouples input arrival from decode latency for up to `BLOCKS` codewords in flight.

## Interface
- `P`, `BCH_SANE`: BCH parameter word; supplies data length K = `BCH_DATA_BITS(P)`.
- `BITS`, 1: bits per cycle; must equal the decoder's `BITS`.
- `BLOCKS`, 2: codewords of buffering; ≥1.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `in_data` in BITS: raw data word, bit 0 first in codeword order.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: buffer can accept a word.
- `err` in BITS: error mask from decoder.
- `err_valid` in 1: `err` valid.
- `err_first` in 1: first mask of a codeword.
- `err_last` in 1: last mask of a codeword.
- `out_data` out BITS: corrected word.
- `out_valid` out 1: `out_data` valid.
- `out_first` out 1: first corrected word of codeword.
- `out_last` out 1: last corrected word of codeword.
- `underflow` out 1: sticky; mask arrived with buffer empty.

## Operation
- WORDS = ceil(K/BITS); CAP = BLOCKS*WORDS words of storage.
- Write pointer, read pointer (0..CAP-1, explicit wrap CAP-1→0, CAP need not be power of 2), occupancy count 0..CAP.
- Write: `in_valid && in_ready` stores `in_data` at wr_ptr, advances it.
- Read: `err_valid` with count>0 reads rd_ptr, registers `mem ^ err` to `out_data`, advances rd_ptr.
- Simultaneous write and read: count unchanged; both pointers advance.
- Per-block word counter (0..WORDS-1) tracks read position; `out_first`/`out_last` derived from it, not from `err_first`/`err_last`.
- Framing check: `err_first` asserted while word counter ≠ 0 resynchronises: counter forced to 0 for that word.
- Final word padding: bits at index ≥ K mod BITS (when nonzero) forced to 0 on `out_data`.
- Underflow: `err_valid` with count==0 sets `underflow`, produces no output, no pointer movement. Cleared only by reset.
- No backpressure on output; downstream must accept every `out_valid` cycle.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_first`=0, `out_last`=0, `underflow`=0, `in_ready`=1, pointers/count/word counter=0.
- `in_ready` = (count < CAP), from registered count only; no combinational path from `err_valid`.
- Latency `err_valid` → `out_valid`: 1 cycle. Data written on cycle n readable by `err_valid` on cycle n+1 or later.
- Full: `in_ready`=0; a read in that cycle frees a slot visible next cycle.
- Reset asserted mid-block: all state cleared immediately; partial blocks discarded.

## Configuration
- `BCH_ERR_APPLY_COUNT_EN` defined: adds output `corrected` (32 bits), saturating count of set bits in every applied `err` word (excluding padding), reset to 0, updated one cycle after the read along with `out_data`.
- Undefined: port and counter absent; no other behaviour changes.

## Structure
- WORDS/CAP computation and pointer-width function (`log2`) belong in the shared `bch.vh` helpers; `BCH_DATA_BITS`/`BCH_PARAM_SZ` from `bch_defs.vh`.
- One sub-module: `bch_sdp_ram` (simple dual-port, registered read, CAP×BITS), instantiated once.

## Test plan
- BITS=1, one block, all-zero `err` → output equals input bit-for-bit; `out_first` on word 0, `out_last` on word K-1.
- BITS=8, `err`=8'h81 on word 3 of block with data 8'hFF → word 3 out = 8'h7E, others unchanged.
- BLOCKS=2, write 2 full blocks with no `err_valid` → `in_ready` drops after word CAP-1; one read cycle → `in_ready`=1 next cycle.
- `err_valid` at reset exit with empty buffer → `underflow`=1, `out_valid` stays 0; persists until `reset`.
- Continuous simultaneous write/read across CAP-1→0 wrap for 3 blocks → count constant, data correct, framing intact.
- `reset` pulsed mid-block → all outputs 0, `in_ready`=1 next edge; fresh block decodes correctly.
